// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: edge-detected byte capture into a FWFT circular FIFO
// with level, threshold interrupt and sticky overrun. Optional error filter: UART_RXF_ERR_FILTER_EN.
module uart_rx_fifo #(
  parameter int ADDR_W = 4,
  parameter int THRESH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              parity_error,
  input  logic              framing_error,
  input  logic              rd_ready,
  input  logic              flush,
  input  logic              clr_overrun,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              rd_perr,
  output logic              rd_ferr,
  output logic [ADDR_W:0]   level,
  output logic              thr_irq,
  output logic              overrun
`ifdef UART_RXF_ERR_FILTER_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_THR  = (ADDR_W+1)'(THRESH);

  logic [9:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rx_done_q;
  logic              wr_stb;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [9:0]        head;

  assign wr_stb   = rx_done & ~rx_done_q;
  assign full     = (level == LVL_FULL);
  assign rd_valid = (level != '0);
  assign pop      = rd_valid & rd_ready;

`ifdef UART_RXF_ERR_FILTER_EN
  logic err_in;
  assign err_in = parity_error | framing_error;
  assign push   = wr_stb & ~err_in & (~full | pop);
  assign drop   = wr_stb & ~err_in & full & ~pop;
`else
  assign push   = wr_stb & (~full | pop);
  assign drop   = wr_stb & full & ~pop;
`endif

  assign head    = mem[rd_ptr];
  assign rd_data = rd_valid ? head[7:0] : '0;
`ifdef UART_RXF_ERR_FILTER_EN
  assign rd_perr = 1'b0;
  assign rd_ferr = 1'b0;
`else
  assign rd_perr = rd_valid & head[8];
  assign rd_ferr = rd_valid & head[9];
`endif
  assign thr_irq = (level >= LVL_THR);

  // rx_done_q resets high so a byte straddling reset release is not captured
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_done_q <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overrun   <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + ADDR_W'(1);
        if (pop)
          rd_ptr <= rd_ptr + ADDR_W'(1);
        if (push && !pop)
          level <= level + (ADDR_W+1)'(1);
        else if (pop && !push)
          level <= level - (ADDR_W+1)'(1);
      end
      if (drop && !flush)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wr_ptr] <= {framing_error, parity_error, rx_data};
  end

`ifdef UART_RXF_ERR_FILTER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_cnt <= '0;
    else if (flush)
      err_cnt <= '0;
    else if (wr_stb && err_in && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo (ADDR_W=4, THRESH=8); also builds with UART_RXF_ERR_FILTER_EN.
module tb_uart_rx_fifo;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rx_done = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              parity_error = 1'b0;
  logic              framing_error = 1'b0;
  logic              rd_ready = 1'b0;
  logic              flush = 1'b0;
  logic              clr_overrun = 1'b0;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic              rd_perr;
  logic              rd_ferr;
  logic [ADDR_W:0]   level;
  logic              thr_irq;
  logic              overrun;
`ifdef UART_RXF_ERR_FILTER_EN
  logic [7:0]        err_cnt;
  int unsigned       m_err = 0;
`endif

  uart_rx_fifo #(.ADDR_W(ADDR_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .parity_error(parity_error), .framing_error(framing_error),
    .rd_ready(rd_ready), .flush(flush), .clr_overrun(clr_overrun),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr),
    .level(level), .thr_irq(thr_irq), .overrun(overrun)
`ifdef UART_RXF_ERR_FILTER_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [9:0] exp_q[$];
  logic       m_ovr = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".level"},   32'(level),    32'(exp_q.size()));
    check({tag, ".valid"},   32'(rd_valid), 32'(exp_q.size() != 0));
    check({tag, ".thr_irq"}, 32'(thr_irq),  32'(exp_q.size() >= THRESH));
    check({tag, ".overrun"}, 32'(overrun),  32'(m_ovr));
`ifdef UART_RXF_ERR_FILTER_EN
    check({tag, ".err_cnt"}, 32'(err_cnt),  32'(m_err));
`endif
  endtask

  task automatic check_head(input string tag);
    logic [9:0] e;
    check({tag, ".valid"}, 32'(rd_valid), 32'(1));
    if (exp_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'(0), 32'(1));
    end else begin
      e = exp_q[0];
      check({tag, ".data"}, 32'(rd_data), 32'(e[7:0]));
`ifdef UART_RXF_ERR_FILTER_EN
      check({tag, ".perr"}, 32'(rd_perr), 32'(0));
      check({tag, ".ferr"}, 32'(rd_ferr), 32'(0));
`else
      check({tag, ".perr"}, 32'(rd_perr), 32'(e[8]));
      check({tag, ".ferr"}, 32'(rd_ferr), 32'(e[9]));
`endif
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic pe, input logic fe, input int len);
    rx_done = 1'b1; rx_data = d; parity_error = pe; framing_error = fe;
    repeat (len) tick;
    rx_done = 1'b0; parity_error = 1'b0; framing_error = 1'b0;
    tick;
`ifdef UART_RXF_ERR_FILTER_EN
    if (pe || fe) begin
      if (m_err != 255) m_err++;
    end else
`endif
    if (exp_q.size() < DEPTH) exp_q.push_back({fe, pe, d});
    else m_ovr = 1'b1;
    check_state("push");
  endtask

  task automatic pop_one;
    check_head("pop");
    rd_ready = 1'b1;
    tick;
    rd_ready = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    check_state("pop");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    #3;
    check("rst.level", 32'(level), 32'(0));
    check("rst.valid", 32'(rd_valid), 32'(0));
    check("rst.data", 32'(rd_data), 32'(0));
    check("rst.thr", 32'(thr_irq), 32'(0));
    check("rst.ovr", 32'(overrun), 32'(0));
    tick; tick;
    rst = 1'b1;
    tick; tick;
    check_state("idle");

    // long rx_done pulse: one entry only
    push_byte(8'h55, 1'b0, 1'b0, 20);
    pop_one;
    check("empty.data", 32'(rd_data), 32'(0));

    // fill, threshold, overrun, ordered drain
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'b0, 1'b0, 2);
    push_byte(8'hAA, 1'b0, 1'b0, 1);
    check("full.ovr", 32'(overrun), 32'(1));
    for (int i = 0; i < DEPTH; i++) pop_one;

    // clear overrun, then simultaneous push+pop while full
    clr_overrun = 1'b1; tick; clr_overrun = 1'b0; m_ovr = 1'b0;
    check_state("clr");
    for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i), 1'b0, 1'b0, 1);
    check_head("fullpp");
    rx_done = 1'b1; rx_data = 8'hC3; rd_ready = 1'b1;
    tick;
    rx_done = 1'b0; rd_ready = 1'b0;
    void'(exp_q.pop_front()); exp_q.push_back({2'b00, 8'hC3});
    tick;
    check_state("fullpp");
    // clr_overrun coincident with a full drop: set wins
    rx_done = 1'b1; rx_data = 8'hEE; clr_overrun = 1'b1;
    tick;
    rx_done = 1'b0; clr_overrun = 1'b0; m_ovr = 1'b1;
    tick;
    check_state("setwins");
    for (int i = 0; i < DEPTH; i++) pop_one;

    // error flags
    push_byte(8'h81, 1'b1, 1'b1, 1);
    if (exp_q.size() != 0) pop_one;
    push_byte(8'h42, 1'b1, 1'b0, 1);
    if (exp_q.size() != 0) pop_one;

    // wrap with push/pop pairs at level 3
    for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i), 1'b0, 1'b0, 1);
    for (int i = 0; i < 24; i++) begin
      check_head("pair");
      rx_done = 1'b1; rx_data = 8'h40 + 8'(i); rd_ready = 1'b1;
      tick;
      rx_done = 1'b0; rd_ready = 1'b0;
      void'(exp_q.pop_front()); exp_q.push_back({2'b00, 8'h40 + 8'(i)});
      tick;
      check_state("pair");
    end

    // flush with coincident push
    rx_done = 1'b1; rx_data = 8'hF0; flush = 1'b1;
    tick;
    rx_done = 1'b0; flush = 1'b0;
    exp_q.delete();
`ifdef UART_RXF_ERR_FILTER_EN
    m_err = 0;
`endif
    tick;
    check_state("flush");
    check("flush.data", 32'(rd_data), 32'(0));
    push_byte(8'h77, 1'b0, 1'b0, 1);
    pop_one;

    // reset mid-operation with rx_done high across release
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i), 1'b0, 1'b0, 1);
    rx_done = 1'b1; rx_data = 8'hEE; rst = 1'b0;
    #1;
    exp_q.delete(); m_ovr = 1'b0;
`ifdef UART_RXF_ERR_FILTER_EN
    m_err = 0;
`endif
    check_state("midrst");
    tick; tick;
    rst = 1'b1;
    repeat (3) tick;
    check_state("release");
    rx_done = 1'b0;
    tick;
    push_byte(8'h99, 1'b0, 1'b0, 3);
    pop_one;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
